interp_bank_sel: RTL
====================

// Module: interp_bank_sel
// PURPOSE
//  Registered, parametrised bank selector and serialiser for the interpolator datapath.
//  Takes NUM_BANKS banks of LANES signed samples and delivers one bank per output beat
//  over a valid/ready handshake.
//  Direct mode (mode=0): one requested bank per input frame.
//  Sequence mode (mode=1): every bank in order 0..NUM_BANKS-1, with out_last on the final beat.
//  Sits between the filter-tap generation stage and the downstream adder tree.
// PARAMETERS
//  DATA_WIDTH  8   base pixel width; each sample is SAMPLE_W = DATA_WIDTH+2 bits, signed
//  LANES       16  samples per bank
//  NUM_BANKS   3   banks per input frame (>=1)
//  localparam SAMPLE_W = DATA_WIDTH+2
//  localparam SEL_W = max(1, clog2(NUM_BANKS))
// PORTS
//  clk       in   1                          system clock, rising edge
//  rst       in   1                          asynchronous reset, active-high
//  mode      in   1                          0 = direct select, 1 = sequence all banks; sampled at accept
//  sel       in   SEL_W                      bank index for direct mode; sampled at accept
//  in_valid  in   1                          input frame valid
//  in_ready  out  1                          block can accept a frame this cycle
//  in_data   in   NUM_BANKS*LANES*SAMPLE_W   bank b, lane l at bits [(b*LANES+l)*SAMPLE_W +: SAMPLE_W]
//  out_valid out  1                          output beat valid
//  out_ready in   1                          downstream accepts beat
//  out_data  out  LANES*SAMPLE_W             lane l at bits [l*SAMPLE_W +: SAMPLE_W]
//  out_bank  out  SEL_W                      bank index of the current beat
//  out_last  out  1                          final beat of the frame
//  sel_err   out  1                          1-cycle pulse: direct accept with sel >= NUM_BANKS
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; out_valid, out_data, out_bank, out_last, sel_err = 0.
//    Frame buffer cleared. Any frame in flight is dropped; no partial beats follow reset release.
//  States:
//    IDLE - no beat held
//    HOLD - beat held, out_last=1
//    SEQ  - serialising, more beats remain
//  Definitions: accept = in_valid & in_ready; take = out_valid & out_ready.
//  in_ready = (state==IDLE) | (out_ready & out_last & out_valid).
//    Full throughput (1 frame/cycle) in direct mode.
//    In sequence mode, 1 frame per NUM_BANKS cycles.
//  Latency: accept at edge N -> out_valid=1 with beat 0 from edge N (visible cycle N+1).
//  Direct accept:
//    out_data <= bank[sel]; out_bank <= sel; out_last <= 1; next state HOLD.
//    If sel >= NUM_BANKS: out_data <= 0, out_bank <= sel, sel_err pulses for 1 cycle,
//      beat still delivered.
//  Sequence accept:
//    Whole in_data latched into buffer; out_data <= bank 0; out_bank <= 0.
//    out_last <= (NUM_BANKS==1); next state SEQ, or HOLD if NUM_BANKS==1.
//  Take in SEQ: out_bank++; out_data <= buffer bank[out_bank+1];
//    out_last <= (out_bank+1 == NUM_BANKS-1); state -> HOLD when last.
//  Take in HOLD with no accept: out_valid <= 0; state -> IDLE.
//  Take in HOLD with simultaneous accept: new beat loaded back-to-back, no bubble.
//  Backpressure: while out_valid & ~out_ready, out_data, out_bank and out_last are held stable.
//  mode and sel changes are ignored except at accept. in_data is ignored outside accept.
//  Samples pass bit-exact; no arithmetic, no sign extension or truncation.
// TESTING (defaults DATA_WIDTH=8, LANES=16, NUM_BANKS=3)
//  1. Direct: bank0 lanes=0..15, bank1=-1 all, bank2=511 all; mode=0, sel=2, out_ready=1
//     -> next cycle out_data=16x511, out_bank=2, out_last=1.
//  2. Sequence: same frame, mode=1, out_ready=1
//     -> 3 consecutive beats bank0, bank1, bank2; out_last only on beat 3;
//        in_ready=1 again on the beat-3 cycle.
//  3. Backpressure: sequence mode, out_ready=0 for 5 cycles after beat 1
//     -> beat 1 held stable, no bank skipped, total 3 beats.
//  4. Direct streaming: in_valid=1 with sel=0,1,2,0 on successive cycles, out_ready=1
//     -> 4 beats on consecutive cycles, in_ready constantly 1.
//  5. Invalid sel=3, mode=0
//     -> out_data=0, out_bank=3, sel_err=1 for exactly 1 cycle.
//  6. Assert rst during sequence beat 2
//     -> all outputs 0 immediately; after release in_ready=1, no residual beats.

Source files
------------

// File: rtl/interp_bank_sel.sv
// Bank selector / serialiser for the interpolator datapath.
// Delivers one bank of LANES samples per beat over valid/ready.
module interp_bank_sel #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 16,
  parameter int NUM_BANKS = 3,
  localparam int SAMPLE_W = DATA_WIDTH + 2,
  localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int BANK_W = LANES * SAMPLE_W,
  localparam int FRAME_W = NUM_BANKS * BANK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BANK_W-1:0]  out_data,
  output logic [SEL_W-1:0]   out_bank,
  output logic               out_last,
  output logic               sel_err
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SEQ
  } state_t;

  state_t state;
  state_t state_n;

  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] frame_n;
  logic [BANK_W-1:0]  data_n;
  logic [SEL_W-1:0]   bank_n;
  logic               last_n;
  logic               err_n;

  logic [BANK_W-1:0]  dir_data;
  logic [BANK_W-1:0]  seq_data;

  logic accept;
  logic take;

  assign out_valid = (state != IDLE);
  assign in_ready = (state == IDLE)
                  | (out_ready & out_last & out_valid);
  assign accept = in_valid & in_ready;
  assign take = out_valid & out_ready;

  // Bank muxes: requested bank from the input, next bank from the buffer.
  // Out-of-range selects fall through to zero.
  always_comb begin
    dir_data = '0;
    seq_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(sel) == b)
        dir_data = in_data[b*BANK_W +: BANK_W];
      if (int'(out_bank) + 1 == b)
        seq_data = frame[b*BANK_W +: BANK_W];
    end
  end

  // Next-state and next-beat logic; an accept overrides the drain path.
  always_comb begin
    state_n = state;
    frame_n = frame;
    data_n  = out_data;
    bank_n  = out_bank;
    last_n  = out_last;
    err_n   = 1'b0;

    case (state)
      SEQ: begin
        if (take) begin
          bank_n  = out_bank + SEL_W'(1);
          data_n  = seq_data;
          last_n  = (int'(out_bank) + 1 == NUM_BANKS - 1);
          state_n = last_n ? HOLD : SEQ;
        end
      end
      HOLD: begin
        if (take)
          state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (accept) begin
      if (mode) begin
        frame_n = in_data;
        data_n  = in_data[BANK_W-1:0];
        bank_n  = '0;
        last_n  = (NUM_BANKS == 1);
        state_n = (NUM_BANKS == 1) ? HOLD : SEQ;
      end else begin
        data_n  = dir_data;
        bank_n  = sel;
        last_n  = 1'b1;
        err_n   = (int'(sel) >= NUM_BANKS);
        state_n = HOLD;
      end
    end
  end

  // State, frame buffer and output beat registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      frame    <= '0;
      out_data <= '0;
      out_bank <= '0;
      out_last <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      state    <= state_n;
      frame    <= frame_n;
      out_data <= data_n;
      out_bank <= bank_n;
      out_last <= last_n;
      sel_err  <= err_n;
    end
  end

endmodule
